// File: rtl/regfile_sweep_if.sv
// Bus bundle for regfile_sweep: two combinational read ports, one write port,
// the flush request and the busy / wr_err status lines.
interface regfile_sweep_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          flush;
    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic [AW-1:0] wn;
    logic [DW-1:0] d;
    logic          we;
    logic          busy;
    logic          wr_err;

    modport master (
        output flush, rna, rnb, wn, d, we,
        input  qa, qb, busy, wr_err
    );

    modport slave (
        input  flush, rna, rnb, wn, d, we,
        output qa, qb, busy, wr_err
    );
endinterface

// File: rtl/regfile_sweep.sv
// 2-read/1-write register file cleared by a one-entry-per-cycle sweep after clr or flush.
// Define REGFILE_BYPASS_EN to forward a committing write to a matching read port in the same cycle.
module regfile_sweep #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int R0_ZERO = 1
) (
    input  logic           clk,
    input  logic           clr,
    regfile_sweep_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] ptr_reg, ptr_next;
    logic          wr_err_reg, wr_err_next;
    logic          sweep_step;
    logic          wn_is_r0;
    logic          commit;

    logic [DW-1:0] mem [DEPTH];

    assign wn_is_r0 = (R0_ZERO != 0) && (bus.wn == '0);
    assign commit   = (state_reg == IDLE) && !bus.flush && !clr && bus.we && !wn_is_r0;

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg  <= SWEEP;
            ptr_reg    <= '0;
            wr_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            wr_err_reg <= wr_err_next;
        end
    end

    // Next-state logic; flush restarts the sweep from entry 0 in either state
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sweep_step = 1'b0;
        if (bus.flush) begin
            state_next = SWEEP;
            ptr_next   = '0;
        end else if (state_reg == SWEEP) begin
            sweep_step = 1'b1;
            if (ptr_reg == AW'(DEPTH - 1)) begin
                state_next = IDLE;
                ptr_next   = '0;
            end else begin
                ptr_next = ptr_reg + 1'b1;
            end
        end
        wr_err_next = bus.we && !wn_is_r0 && (bus.flush || (state_reg == SWEEP));
    end

    // Outputs
    always_comb begin
        bus.busy   = (state_reg == SWEEP);
        bus.wr_err = wr_err_reg;
    end

    // Storage: sweep clear and writeback commit are mutually exclusive by construction
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (sweep_step) begin
                mem[ptr_reg] <= '0;
            end else if (commit) begin
                mem[bus.wn] <= bus.d;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic [DW-1:0] q;

            assign addr = (gi == 0) ? bus.rna : bus.rnb;

            // Later assignments take precedence: busy, then r0, then forwarding
            always_comb begin
                q = mem[addr];
`ifdef REGFILE_BYPASS_EN
                if (commit && (bus.wn == addr)) begin
                    q = bus.d;
                end
`endif
                if ((R0_ZERO != 0) && (addr == '0)) begin
                    q = '0;
                end
                if (state_reg == SWEEP) begin
                    q = '0;
                end
            end
        end
    endgenerate

    assign bus.qa = g_rd[0].q;
    assign bus.qb = g_rd[1].q;
endmodule
